// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM, single-byte
// holding register with VALID/RD handshake plus framing-error and overrun pulses.
module uart_rx #(
    parameter int BIT_CLKS = 868
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    input  logic       RD,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       BUSY,
    output logic       FRAME_ERR,
    output logic       OVERRUN
);

    localparam int TW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [TW-1:0] FULL = TW'(BIT_CLKS - 1);
    localparam logic [TW-1:0] HALF = TW'(BIT_CLKS / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    state_t          state;
    logic            rxd_meta;
    logic            rxd_sync;
    logic            rxd_prev;
    logic [1:0]      warm;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rxd_meta  <= 1'b1;
            rxd_sync  <= 1'b1;
            rxd_prev  <= 1'b0;
            warm      <= 2'b00;
            state     <= ST_IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            DATA      <= '0;
            VALID     <= 1'b0;
            BUSY      <= 1'b0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            rxd_meta <= RXD;
            rxd_sync <= rxd_meta;
            // The synchronizer's reset value is not a real observation of the line,
            // so the edge detector only counts the line as high once real samples arrive.
            warm     <= {warm[0], 1'b1};
            rxd_prev <= warm[1] & rxd_sync;

            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
            if (RD) begin
                VALID <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (rxd_prev && !rxd_sync) begin
                        timer <= HALF;
                        state <= ST_START;
                        BUSY  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (timer == '0) begin
                        if (!rxd_sync) begin
                            timer   <= FULL;
                            bit_idx <= '0;
                            state   <= ST_DATA;
                        end else begin
                            state <= ST_IDLE;
                            BUSY  <= 1'b0;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ST_DATA: begin
                    if (timer == '0) begin
                        shreg[bit_idx] <= rxd_sync;
                        timer          <= FULL;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ST_STOP: begin
                    if (timer == '0) begin
                        if (rxd_sync) begin
                            // A read in this same cycle is overridden: the new byte wins.
                            DATA    <= shreg;
                            VALID   <= 1'b1;
                            OVERRUN <= VALID & ~RD;
                            state   <= ST_IDLE;
                            BUSY    <= 1'b0;
                        end else begin
                            FRAME_ERR <= 1'b1;
                            state     <= ST_WAIT_IDLE;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rxd_sync) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected frame outcomes into a
// queue, an independent monitor pops them whenever the receiver reports something.
module tb_uart_rx;

    localparam int B = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RXD = 1'b1;
    logic       RD  = 1'b0;
    logic [7:0] DATA;
    logic       VALID;
    logic       BUSY;
    logic       FRAME_ERR;
    logic       OVERRUN;

    uart_rx #(.BIT_CLKS(B)) dut (
        .CLK(CLK),
        .RST(RST),
        .RXD(RXD),
        .RD(RD),
        .DATA(DATA),
        .VALID(VALID),
        .BUSY(BUSY),
        .FRAME_ERR(FRAME_ERR),
        .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit         fe;
        logic [7:0] data;
        bit         ov;
        bit         vld;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   ov_count = 0;
    int   last_evt_cyc = -1;

    // Reference model of what the consumer should see: last good byte and unread flag.
    bit         pending = 1'b0;
    logic [7:0] last_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic expect_good(input logic [7:0] b);
        q.push_back('{fe: 1'b0, data: b, ov: pending, vld: 1'b1});
        pending   = 1'b1;
        last_data = b;
    endtask

    task automatic expect_bad();
        q.push_back('{fe: 1'b1, data: last_data, ov: 1'b0, vld: pending});
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        RXD = 1'b0;
        tick(B);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            tick(B);
        end
        RXD = stop_ok;
        tick(B);
    endtask

    task automatic rd_pulse();
        RD = 1'b1;
        tick(1);
        RD = 1'b0;
        pending = 1'b0;
        chk("valid_after_rd", {31'b0, VALID}, 32'd0);
    endtask

    // Monitor
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_fe = 1'b0;
    logic       prev_ov = 1'b0;
    exp_t       e;

    always @(negedge CLK) begin
        if (!RST) begin
            if (FRAME_ERR) chk("fe_pulse_width", {31'b0, prev_fe}, 32'd0);
            if (OVERRUN) begin
                chk("ov_pulse_width", {31'b0, prev_ov}, 32'd0);
                ov_count++;
            end
            if (FRAME_ERR || OVERRUN || (VALID && (!prev_valid || DATA != prev_data))) begin
                last_evt_cyc = cyc;
                if (q.size() == 0) begin
                    chk("unexpected_event", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("evt_kind_fe", {31'b0, FRAME_ERR}, {31'b0, e.fe});
                    chk("evt_data", {24'b0, DATA}, {24'b0, e.data});
                    chk("evt_valid", {31'b0, VALID}, {31'b0, e.vld});
                    chk("evt_overrun", {31'b0, OVERRUN}, {31'b0, e.ov});
                end
            end
        end
        prev_valid = VALID;
        prev_data  = DATA;
        prev_fe    = FRAME_ERR;
        prev_ov    = OVERRUN;
    end

    int  s;
    int  lat;
    int  oc;
    bit  ok;
    logic [7:0] b;
    bit  good;

    initial begin
        // Reset state
        RST = 1'b1;
        tick(3);
        chk("rst_data", {24'b0, DATA}, 32'd0);
        chk("rst_valid", {31'b0, VALID}, 32'd0);
        chk("rst_busy", {31'b0, BUSY}, 32'd0);
        chk("rst_fe", {31'b0, FRAME_ERR}, 32'd0);
        chk("rst_ov", {31'b0, OVERRUN}, 32'd0);
        RST = 1'b0;
        tick(5);

        // Clean 0x55, latency, then read
        s = cyc;
        last_evt_cyc = -1;
        expect_good(8'h55);
        fork
            send_frame(8'h55, 1'b1);
            begin
                tick(80);
                chk("busy_mid_frame", {31'b0, BUSY}, 32'd1);
            end
        join
        lat = last_evt_cyc - s;
        chk("latency_in_range", {31'b0, (lat >= 152 && lat <= 157)}, 32'd1);
        chk("data_55", {24'b0, DATA}, 32'h55);
        chk("valid_55", {31'b0, VALID}, 32'd1);
        rd_pulse();
        tick(5);

        // False start
        RXD = 1'b0;
        tick(4);
        chk("busy_false_start", {31'b0, BUSY}, 32'd1);
        RXD = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick(1);
            if (!BUSY) begin
                ok = 1'b1;
                break;
            end
        end
        chk("false_start_busy_drop", {31'b0, ok}, 32'd1);
        tick(20);
        chk("false_start_valid", {31'b0, VALID}, 32'd0);

        // 0xA3 with low stop bit, line held low afterwards
        expect_bad();
        send_frame(8'hA3, 1'b0);
        tick(40);
        chk("wait_idle_busy", {31'b0, BUSY}, 32'd1);
        chk("fe_valid_kept", {31'b0, VALID}, 32'd0);
        chk("fe_data_kept", {24'b0, DATA}, 32'h55);
        RXD = 1'b1;
        tick(6);
        chk("wait_idle_exit", {31'b0, BUSY}, 32'd0);
        tick(10);

        // Back-to-back 0x12, 0x34 without reading
        oc = ov_count;
        expect_good(8'h12);
        expect_good(8'h34);
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        tick(5);
        chk("overrun_count", ov_count - oc, 32'd1);
        chk("data_34", {24'b0, DATA}, 32'h34);
        chk("valid_34", {31'b0, VALID}, 32'd1);

        // 0x7E completes in the same cycle as RD
        oc = ov_count;
        q.push_back('{fe: 1'b0, data: 8'h7E, ov: 1'b0, vld: 1'b1});
        last_data = 8'h7E;
        pending   = 1'b1;
        fork
            send_frame(8'h7E, 1'b1);
            begin
                repeat (lat - 1) @(posedge CLK);
                #1 RD = 1'b1;
                @(posedge CLK);
                #1 RD = 1'b0;
            end
        join
        tick(5);
        chk("data_7e", {24'b0, DATA}, 32'h7E);
        chk("valid_7e", {31'b0, VALID}, 32'd1);
        chk("no_overrun_7e", ov_count - oc, 32'd0);

        // Reset in the middle of data bit 3 of 0xF5
        b = 8'hF5;
        RXD = 1'b0;
        tick(B);
        for (int i = 0; i < 3; i++) begin
            RXD = b[i];
            tick(B);
        end
        RXD = b[3];
        tick(B / 2);
        RST = 1'b1;
        tick(1);
        chk("midrst_data", {24'b0, DATA}, 32'd0);
        chk("midrst_valid", {31'b0, VALID}, 32'd0);
        chk("midrst_busy", {31'b0, BUSY}, 32'd0);
        chk("midrst_fe", {31'b0, FRAME_ERR}, 32'd0);
        chk("midrst_ov", {31'b0, OVERRUN}, 32'd0);
        RST = 1'b0;
        pending   = 1'b0;
        last_data = 8'h00;
        tick(B / 2);
        for (int i = 4; i < 8; i++) begin
            RXD = b[i];
            tick(B);
        end
        RXD = 1'b1;
        tick(B + 30);
        chk("post_rst_no_valid", {31'b0, VALID}, 32'd0);
        chk("post_rst_idle", {31'b0, BUSY}, 32'd0);
        expect_good(8'hC9);
        send_frame(8'hC9, 1'b1);
        tick(5);
        chk("data_c9", {24'b0, DATA}, 32'hC9);
        chk("valid_c9", {31'b0, VALID}, 32'd1);
        rd_pulse();
        tick(5);

        // Randomized frames: random payload, occasional bad stop, occasional skipped read
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 7) != 0);
            if (good) expect_good(b);
            else expect_bad();
            send_frame(b, good);
            RXD = 1'b1;
            tick(2);
            if (pending && $urandom_range(0, 3) != 0) rd_pulse();
            tick($urandom_range(3, 20));
        end

        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        chk("queue_drained", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
